ifm_chunk_loader: RTL
=====================

# ifm_chunk_loader

Upstream feeder of the double-buffered IFM chunk combiner. It accepts compressed IFM beats (sparsemap bits plus nonzero bytes) over a valid/ready stream and packs them into chunks of `MEM_SIZE/BUS_SIZE` beats. It steers each chunk into the free bank of the ping-pong buffer and tracks which bank is full. It then tells the compute side which bank to read (`rd_sel_o`, `chunk_start_o`), and recycles a bank when the compute side releases it.

## Interface
Parameters:
- BUS_SIZE, `` `BUS_SIZE``: sparsemap bits, and nonzero bytes, per beat.
- MEM_SIZE, `` `MEM_SIZE``: bytes per chunk bank.
- WR_DAT_CYC_NUM, MEM_SIZE/BUS_SIZE (localparam): beats per chunk; power of two, ≥2.

Ports:
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  loader can accept a beat.
- in_sparsemap_i  in  BUS_SIZE  sparsemap bits of the beat.
- in_nonzero_data_i  in  BUS_SIZE×8  nonzero bytes of the beat.
- wr_valid_o  out  1  write strobe to the buffer.
- wr_sparsemap_o  out  BUS_SIZE  registered copy of the accepted sparsemap.
- wr_nonzero_data_o  out  BUS_SIZE×8  registered copy of the accepted data.
- wr_count_o  out  clog2(WR_DAT_CYC_NUM)  beat index within the chunk.
- wr_sel_o  out  1  target bank of the current write.
- rd_release_i  in  1  one-cycle pulse: compute side finished bank `rd_sel_o`.
- chunk_start_o  out  1  one-cycle pulse: bank `rd_sel_o` is full; compute may start.
- rd_sel_o  out  1  bank the compute side reads.
- bank_full_o  out  2  per-bank full flags.
- release_err_o  out  1  sticky: release received while no chunk was started.

## Operation
- Input bank pointer `in_bank` and beat counter `in_cnt`:
  - A beat is accepted when in_valid_i && in_ready_o.
  - Each accepted beat increments `in_cnt`.
  - At `in_cnt == WR_DAT_CYC_NUM-1`, an accepted beat wraps `in_cnt` to 0 and toggles `in_bank`.
- in_ready_o = !bank_full_o[in_bank] (combinational from registers only). It does not depend on in_valid_i.
- Write stage (registered):
  - On acceptance: wr_valid_o=1; wr_sparsemap_o and wr_nonzero_data_o capture the beat; wr_count_o=`in_cnt`; wr_sel_o=`in_bank`.
  - Otherwise wr_valid_o=0 and the other wr_* outputs hold their values.
- Full flags:
  - bank_full_o[b] sets at the edge where wr_valid_o && wr_count_o==WR_DAT_CYC_NUM-1 && wr_sel_o==b.
  - It clears at the edge where rd_release_i is accepted in R_BUSY with rd_sel_o==b.
  - A set on one bank and a clear on the other in the same cycle both take effect.
- Reader FSM, states R_IDLE and R_BUSY:
  - R_IDLE && bank_full_o[rd_sel_o]: next cycle chunk_start_o=1 for exactly one cycle, state → R_BUSY.
  - R_BUSY && rd_release_i: clear bank_full_o[rd_sel_o], toggle rd_sel_o, state → R_IDLE.
  - rd_release_i in R_IDLE is ignored and sets release_err_o; it stays set until reset.
- rd_sel_o changes only on an accepted release. It is stable from chunk_start_o until the matching release.
- Chunks are consumed strictly in the order they were written: bank 0, 1, 0, 1, …

## Timing
- Reset values: in_ready_o=1 (both banks empty), wr_valid_o=0, wr_sparsemap_o=0, wr_nonzero_data_o=0, wr_count_o=0, wr_sel_o=0, chunk_start_o=0, rd_sel_o=0, bank_full_o=2'b00, release_err_o=0, `in_bank`=0, `in_cnt`=0, state R_IDLE.
- Beat accepted at edge N → wr_valid_o high during cycle N+1.
- Last beat accepted at edge N → bank_full_o set during N+2 → chunk_start_o high during N+3 if the FSM is in R_IDLE.
- Release at edge M:
  - bank full flag clears and in_ready_o may rise during M+1.
  - If the other bank is already full, chunk_start_o fires during M+2.
- Both banks full → in_ready_o=0. A beat held valid is accepted in the cycle after the release that frees `in_bank`.
- Reset mid-chunk discards the partial chunk and both banks' contents. A reset asserted in the same cycle as in_valid_i accepts nothing.

## Structure
- Shared package `ifm_pkg`:
  - enum `rd_state_e` {R_IDLE, R_BUSY}.
  - Function deriving WR_DAT_CYC_NUM from the global size macros.
- One sub-module, `ifm_bank_ctrl`: full flags, reader FSM, rd_sel_o, chunk_start_o and release_err_o.
- The top level holds the input counter, the bank pointer and the write-stage registers.

## Test plan
- Reset then one chunk (WR_DAT_CYC_NUM beats, data = beat index) with valid held high:
  - wr_count_o runs 0..N-1 with wr_sel_o=0.
  - bank_full_o=01 two cycles after the last beat.
  - chunk_start_o pulses once with rd_sel_o=0.
- Stream three chunks with no release:
  - banks 0 and 1 fill, then in_ready_o drops on the first beat of the third chunk.
  - Release bank 0 → the third chunk's first beat is accepted, wr_sel_o=0.
  - chunk_start_o fires for bank 1.
- Last beat of bank 1 written in the same cycle as the release of bank 0:
  - bank_full_o goes 01→10 in one edge.
  - chunk_start_o fires for bank 1 two cycles after the release.
- rd_release_i pulse in R_IDLE after reset → release_err_o=1; no state change; bank_full_o unchanged.
- Reset asserted after 3 beats of a chunk → all outputs return to reset values. The next chunk is written to bank 0 starting at wr_count_o=0.
- Random in_valid_i gaps over 4 chunks with delayed releases → wr_* contents match the input beats. Chunks are started in order 0,1,0,1 with exactly one chunk_start_o per chunk.

Source files
------------

// File: rtl/ifm_pkg.sv
// Shared types and chunk geometry for the IFM chunk loader.
// Size macros fall back to a small default geometry when the build does not supply them.
`ifndef BUS_SIZE
`define BUS_SIZE 4
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 16
`endif

package ifm_pkg;
  typedef enum logic {R_IDLE = 1'b0, R_BUSY = 1'b1} rd_state_e;

  localparam int BUS_SIZE_DEF = `BUS_SIZE;
  localparam int MEM_SIZE_DEF = `MEM_SIZE;

  function automatic int wr_dat_cyc_num(input int bus_size, input int mem_size);
    return mem_size / bus_size;
  endfunction

  localparam int WR_DAT_CYC_NUM = wr_dat_cyc_num(BUS_SIZE_DEF, MEM_SIZE_DEF);
  localparam int CNT_W_DEF      = $clog2(WR_DAT_CYC_NUM);
endpackage

// File: rtl/ifm_chunk_loader_if.sv
// Beat stream, buffer write port and bank handshake of the IFM chunk loader.
interface ifm_chunk_loader_if
  import ifm_pkg::*;
#(
  parameter int BUS_SIZE = BUS_SIZE_DEF,
  parameter int CNT_W    = CNT_W_DEF
);
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [BUS_SIZE-1:0]     in_sparsemap_i;
  logic [BUS_SIZE*8-1:0]   in_nonzero_data_i;
  logic                    wr_valid_o;
  logic [BUS_SIZE-1:0]     wr_sparsemap_o;
  logic [BUS_SIZE*8-1:0]   wr_nonzero_data_o;
  logic [CNT_W-1:0]        wr_count_o;
  logic                    wr_sel_o;
  logic                    rd_release_i;
  logic                    chunk_start_o;
  logic                    rd_sel_o;
  logic [1:0]              bank_full_o;
  logic                    release_err_o;

  // slave is the loader, master is the upstream/compute environment
  modport slave (
    input  in_valid_i, in_sparsemap_i, in_nonzero_data_i, rd_release_i,
    output in_ready_o, wr_valid_o, wr_sparsemap_o, wr_nonzero_data_o, wr_count_o,
           wr_sel_o, chunk_start_o, rd_sel_o, bank_full_o, release_err_o
  );
  modport master (
    output in_valid_i, in_sparsemap_i, in_nonzero_data_i, rd_release_i,
    input  in_ready_o, wr_valid_o, wr_sparsemap_o, wr_nonzero_data_o, wr_count_o,
           wr_sel_o, chunk_start_o, rd_sel_o, bank_full_o, release_err_o
  );
endinterface

// File: rtl/ifm_bank_ctrl.sv
// Ping-pong bank bookkeeping: full flags, reader FSM, read select and release error.
module ifm_bank_ctrl
  import ifm_pkg::*;
#(
  parameter int CNT_W  = 2,
  parameter int WR_CYC = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_valid_i,
  input  logic [CNT_W-1:0] wr_count_i,
  input  logic             wr_sel_i,
  input  logic             rd_release_i,
  output logic [1:0]       bank_full_o,
  output logic             rd_sel_o,
  output logic             chunk_start_o,
  output logic             release_err_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WR_CYC - 1);

  rd_state_e  state_q, state_d;
  logic       start_d, rel_acc, rel_err;
  logic [1:0] set_vec, clr_vec;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= R_IDLE;
    else       state_q <= state_d;
  end

  // A release seen while idle is dropped and only flagged.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    rel_acc = 1'b0;
    rel_err = 1'b0;
    case (state_q)
      R_IDLE: begin
        rel_err = rd_release_i;
        if (bank_full_o[rd_sel_o]) begin
          state_d = R_BUSY;
          start_d = 1'b1;
        end
      end
      R_BUSY: begin
        if (rd_release_i) begin
          state_d = R_IDLE;
          rel_acc = 1'b1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign set_vec = (wr_valid_i && wr_count_i == LAST) ? (2'b01 << wr_sel_i) : 2'b00;
  assign clr_vec = rel_acc ? (2'b01 << rd_sel_o) : 2'b00;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_full_o   <= 2'b00;
      rd_sel_o      <= 1'b0;
      chunk_start_o <= 1'b0;
      release_err_o <= 1'b0;
    end else begin
      bank_full_o   <= (bank_full_o | set_vec) & ~clr_vec;
      rd_sel_o      <= rd_sel_o ^ rel_acc;
      chunk_start_o <= start_d;
      release_err_o <= release_err_o | rel_err;
    end
  end
endmodule

// File: rtl/ifm_chunk_loader.sv
// Packs compressed IFM beats into chunks and steers them into a ping-pong buffer.
module ifm_chunk_loader
  import ifm_pkg::*;
#(
  parameter int BUS_SIZE = BUS_SIZE_DEF,
  parameter int MEM_SIZE = MEM_SIZE_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ifm_chunk_loader_if.slave bus
);
  localparam int               WR_CYC = wr_dat_cyc_num(BUS_SIZE, MEM_SIZE);
  localparam int               CNT_W  = $clog2(WR_CYC);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(WR_CYC - 1);

  logic             in_bank;
  logic [CNT_W-1:0] in_cnt;
  logic             in_ready, accept;
  logic [1:0]       bank_full;

  // Ready looks only at registered state, never at in_valid_i.
  assign in_ready       = ~bank_full[in_bank];
  assign accept         = bus.in_valid_i & in_ready;
  assign bus.in_ready_o = in_ready;
  assign bus.bank_full_o = bank_full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_bank               <= 1'b0;
      in_cnt                <= '0;
      bus.wr_valid_o        <= 1'b0;
      bus.wr_sparsemap_o    <= '0;
      bus.wr_nonzero_data_o <= '0;
      bus.wr_count_o        <= '0;
      bus.wr_sel_o          <= 1'b0;
    end else begin
      bus.wr_valid_o <= accept;
      if (accept) begin
        in_cnt                <= (in_cnt == LAST) ? '0 : in_cnt + 1'b1;
        in_bank               <= in_bank ^ (in_cnt == LAST);
        bus.wr_sparsemap_o    <= bus.in_sparsemap_i;
        bus.wr_nonzero_data_o <= bus.in_nonzero_data_i;
        bus.wr_count_o        <= in_cnt;
        bus.wr_sel_o          <= in_bank;
      end
    end
  end

  ifm_bank_ctrl #(.CNT_W(CNT_W), .WR_CYC(WR_CYC)) u_bank_ctrl (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .wr_valid_i    (bus.wr_valid_o),
    .wr_count_i    (bus.wr_count_o),
    .wr_sel_i      (bus.wr_sel_o),
    .rd_release_i  (bus.rd_release_i),
    .bank_full_o   (bank_full),
    .rd_sel_o      (bus.rd_sel_o),
    .chunk_start_o (bus.chunk_start_o),
    .release_err_o (bus.release_err_o)
  );
endmodule
